// File: rtl/wormhole_grant_holder_pkg.sv
// Shared types and helpers for the wormhole output-port grant holder.
// Holds the FSM state encoding and the index-width helper.
package wormhole_grant_holder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int log2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wormhole_grant_holder_if.sv
// Port bundle between the grant holder, its inputs, the arbiter and the crossbar.
// The slave side is the grant holder; the master side drives its inputs.
interface wormhole_grant_holder_if
  import wormhole_grant_holder_pkg::*;
#(
  parameter int PORT_NUM  = 4,
  parameter int CNT_WIDTH = 5
);
  localparam int PORT_BCD_WIDTH = log2(PORT_NUM);

  logic [PORT_NUM-1:0]       flit_valid;
  logic [PORT_NUM-1:0]       flit_is_tail;
  logic                      out_ready;
  logic [PORT_NUM-1:0]       arb_request;
  logic [PORT_BCD_WIDTH-1:0] grant_bcd;
  logic                      any_grant;
  logic [PORT_NUM-1:0]       grant_onehot;
  logic [PORT_BCD_WIDTH-1:0] sel_bcd;
  logic                      locked;
  logic [PORT_NUM-1:0]       port_accept;
  logic [CNT_WIDTH-1:0]      flit_cnt;
  logic                      grant_err;

  modport slave (
    input  flit_valid, flit_is_tail, out_ready,
    input  grant_bcd, any_grant,
    output arb_request, grant_onehot, sel_bcd,
    output locked, port_accept, flit_cnt, grant_err
  );

  modport master (
    output flit_valid, flit_is_tail, out_ready,
    output grant_bcd, any_grant,
    input  arb_request, grant_onehot, sel_bcd,
    input  locked, port_accept, flit_cnt, grant_err
  );

endinterface

// File: rtl/wormhole_grant_holder_bcd_to_onehot.sv
// Binary index to one-hot decoder for the crossbar select.
// Out-of-range indices decode to all zeros.
module bcd_to_onehot
  import wormhole_grant_holder_pkg::*;
#(
  parameter int PORT_NUM = 4,
  parameter int BW       = log2(PORT_NUM)
) (
  input  logic [BW-1:0]       bcd,
  output logic [PORT_NUM-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (bcd == BW'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/wormhole_grant_holder.sv
// Output-port grant holder: locks the arbiter winner until its tail flit
// is accepted, masking requests so the arbiter rotates once per packet.
module wormhole_grant_holder
  import wormhole_grant_holder_pkg::*;
#(
  parameter int PORT_NUM  = 4,
  parameter int CNT_WIDTH = 5
) (
  input logic                    clk,
  input logic                    reset,
  wormhole_grant_holder_if.slave bus
);
  localparam int PORT_BCD_WIDTH = log2(PORT_NUM);

  state_e                    state_q, state_d;
  logic [PORT_BCD_WIDTH-1:0] sel_q, sel_d;
  logic [PORT_NUM-1:0]       oh_q, oh_d;
  logic [PORT_NUM-1:0]       oh_dec, acc;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [PORT_NUM-1:0]       req;

  bcd_to_onehot #(
    .PORT_NUM (PORT_NUM),
    .BW       (PORT_BCD_WIDTH)
  ) u_dec (
    .bcd    (bus.grant_bcd),
    .onehot (oh_dec)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    oh_d    = oh_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    acc     = '0;
    req     = '0;
    unique case (state_q)
      IDLE: begin
        req = bus.flit_valid;
        if (bus.any_grant) begin
          if (int'(bus.grant_bcd) < PORT_NUM) begin
            state_d = LOCKED;
            sel_d   = bus.grant_bcd;
            oh_d    = oh_dec;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        acc = oh_q & bus.flit_valid & {PORT_NUM{bus.out_ready}};
        if (|acc) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (|(acc & bus.flit_is_tail)) begin
          state_d = IDLE;
          sel_d   = '0;
          oh_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      oh_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      oh_q    <= oh_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // nothing is consumed from an input while reset is being applied
  assign bus.port_accept  = reset ? acc : '0;
  assign bus.arb_request  = req;
  assign bus.grant_onehot = oh_q;
  assign bus.sel_bcd      = sel_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.flit_cnt     = cnt_q;
  assign bus.grant_err    = err_q;

endmodule
